// File: rtl/accumulator_serial_store_pkg.sv
// Shared definitions for the bit-serial accumulator stages: default word
// geometry, the beat mode encoding, and the mode-selection rule.
package accumulator_serial_store_pkg;

    localparam int WORD_W_DEFAULT = 32;
    localparam int IDX_W_DEFAULT  = 5;

    typedef enum logic [1:0] {
        MODE_RECIRC = 2'd0,
        MODE_WRITE  = 2'd1,
        MODE_ZERO   = 2'd2
    } mode_e;

    // Clear outranks write; with nothing pending the word just recirculates.
    function automatic mode_e select_mode(input logic write_pend, input logic clear_pend);
        if (clear_pend)
            return MODE_ZERO;
        else if (write_pend)
            return MODE_WRITE;
        else
            return MODE_RECIRC;
    endfunction

endpackage

// File: rtl/accumulator_serial_store_if.sv
// Control, serial link and display signals of the accumulator store.
// The master side drives run/strobe/requests and the subtract-unit result;
// the slave side is the store itself.
interface accumulator_serial_store_if
    import accumulator_serial_store_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int IDX_W  = IDX_W_DEFAULT
);
    logic              i_RUN;
    logic              i_BIT_EN;
    logic              i_WRITE;
    logic              i_CLEAR;
    logic              i_ASU_DATA;
    logic              o_A_DATA;
    logic              o_XTB;
    logic [IDX_W-1:0]  o_BIT_IDX;
    logic              o_BEAT_DONE;
    logic [WORD_W-1:0] o_ACC_PAR;
    logic              o_NEG;

    modport master (
        output i_RUN, i_BIT_EN, i_WRITE, i_CLEAR, i_ASU_DATA,
        input  o_A_DATA, o_XTB, o_BIT_IDX, o_BEAT_DONE, o_ACC_PAR, o_NEG
    );

    modport slave (
        input  i_RUN, i_BIT_EN, i_WRITE, i_CLEAR, i_ASU_DATA,
        output o_A_DATA, o_XTB, o_BIT_IDX, o_BEAT_DONE, o_ACC_PAR, o_NEG
    );

endinterface

// File: rtl/accumulator_serial_store_serial_beat_counter.sv
// Bit-time counter shared by the serial stores: tracks the bit position
// inside a beat, flags beat start/end for the owning stage, raises XTB on
// bit-time 0 and emits a registered one-cycle beat-done pulse.
module serial_beat_counter
    import accumulator_serial_store_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int IDX_W  = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             run,
    input  logic             bit_en,
    output logic [IDX_W-1:0] bit_idx,
    output logic             xtb,
    output logic             beat_start,
    output logic             beat_end,
    output logic             beat_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0] idx_reg;
    logic             done_reg;
    logic             advance;

    assign advance    = run & bit_en;
    assign beat_start = advance && (idx_reg == '0);
    assign beat_end   = advance && (idx_reg == LAST_IDX);
    assign xtb        = run && (idx_reg == '0);
    assign bit_idx    = idx_reg;
    assign beat_done  = done_reg;

    // Step the bit index on every advance, wrapping at the last bit; the
    // done pulse lasts exactly the cycle after the final bit is shifted.
    always_ff @(posedge clk) begin
        if (srst) begin
            idx_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= beat_end;
            if (advance)
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/accumulator_serial_store.sv
// Bit-serial accumulator store. Recirculates the accumulator word LSB-first
// toward the subtract unit, captures the unit's serial result in write
// beats, zeroes it in clear beats, and keeps a parallel snapshot of the
// last completed word for the display and sign test.
module accumulator_serial_store
    import accumulator_serial_store_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int IDX_W  = IDX_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    accumulator_serial_store_if.slave bus
);

    logic              advance;
    logic              beat_start;
    logic              beat_end;

    logic              write_pend_reg, write_pend_next;
    logic              clear_pend_reg, clear_pend_next;
    mode_e             mode_reg, mode_next;
    mode_e             eff_mode;
    logic              in_bit;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [WORD_W-1:0] word_shift;
    logic [WORD_W-1:0] acc_par_reg;

    assign advance = bus.i_RUN & bus.i_BIT_EN;

    serial_beat_counter #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_beat_counter (
        .clk        (clk),
        .srst       (rst),
        .run        (bus.i_RUN),
        .bit_en     (bus.i_BIT_EN),
        .bit_idx    (bus.o_BIT_IDX),
        .xtb        (bus.o_XTB),
        .beat_start (beat_start),
        .beat_end   (beat_end),
        .beat_done  (bus.o_BEAT_DONE)
    );

    // Sticky request latches and mode selection. A request seen on the
    // beat-start cycle itself is folded in before the mode is chosen, so it
    // applies to the beat that is starting; the latches then clear.
    always_comb begin
        write_pend_next = write_pend_reg | bus.i_WRITE;
        clear_pend_next = clear_pend_reg | bus.i_CLEAR;
        mode_next       = mode_reg;
        eff_mode        = mode_reg;
        if (beat_start) begin
            mode_next       = select_mode(write_pend_next, clear_pend_next);
            eff_mode        = mode_next;
            write_pend_next = 1'b0;
            clear_pend_next = 1'b0;
        end
    end

    // Bit entering the MSB end: the outgoing LSB, the subtract result, or zero.
    always_comb begin
        in_bit = word_reg[0];
        case (eff_mode)
            MODE_RECIRC: in_bit = word_reg[0];
            MODE_WRITE:  in_bit = bus.i_ASU_DATA;
            MODE_ZERO:   in_bit = 1'b0;
            default:     in_bit = word_reg[0];
        endcase
    end

    // One-position right shift with the selected bit entering at the top.
    generate
        for (genvar gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
            assign word_shift[gi] = word_reg[gi+1];
        end
    endgenerate
    assign word_shift[WORD_W-1] = in_bit;

    assign word_next = advance ? word_shift : word_reg;

    // State registers; the snapshot takes the fully rotated word on the
    // final bit of each beat. Reset discards any half-written word.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_pend_reg <= 1'b0;
            clear_pend_reg <= 1'b0;
            mode_reg       <= MODE_RECIRC;
            word_reg       <= '0;
            acc_par_reg    <= '0;
        end else begin
            write_pend_reg <= write_pend_next;
            clear_pend_reg <= clear_pend_next;
            mode_reg       <= mode_next;
            word_reg       <= word_next;
            if (beat_end)
                acc_par_reg <= word_shift;
        end
    end

    assign bus.o_A_DATA  = word_reg[0];
    assign bus.o_ACC_PAR = acc_par_reg;
    assign bus.o_NEG     = acc_par_reg[WORD_W-1];

endmodule

// File: tb/tb_accumulator_serial_store.sv
// Bench for the accumulator store with an 8-bit word. Each beat pushes its
// expected snapshot into a queue; a monitor pops and compares it whenever
// the beat-done pulse appears.
module tb_accumulator_serial_store;

    localparam int W  = 8;
    localparam int IW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [W-1:0] sb_q[$];

    accumulator_serial_store_if #(.WORD_W(W), .IDX_W(IW)) bus ();

    accumulator_serial_store #(.WORD_W(W), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: compare the snapshot on every beat-done pulse.
    always @(negedge clk) begin
        if (!rst && bus.o_BEAT_DONE === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [W-1:0] exp_par;
                exp_par = sb_q.pop_front();
                check("acc_par", 32'(bus.o_ACC_PAR), 32'(exp_par));
                check("neg", 32'(bus.o_NEG), 32'(exp_par[W-1]));
                $display("beat done: acc_par=%02h neg=%0b expected=%02h", bus.o_ACC_PAR, bus.o_NEG, exp_par);
            end
        end
    end

    task automatic pulse_req(input logic wr, input logic clr);
        bus.i_WRITE = wr;
        bus.i_CLEAR = clr;
        @(posedge clk); #1;
        bus.i_WRITE = 1'b0;
        bus.i_CLEAR = 1'b0;
    endtask

    task automatic one_strobe(input logic asu, input logic wr, input int exp_idx,
                              input logic exp_a, input logic exp_done);
        check("bit_idx", 32'(bus.o_BIT_IDX), 32'(exp_idx));
        check("a_data", 32'(bus.o_A_DATA), 32'(exp_a));
        check("xtb", 32'(bus.o_XTB), 32'(exp_idx == 0));
        bus.i_BIT_EN   = 1'b1;
        bus.i_ASU_DATA = asu;
        bus.i_WRITE    = wr;
        @(posedge clk); #1;
        bus.i_BIT_EN   = 1'b0;
        bus.i_WRITE    = 1'b0;
        check("beat_done", 32'(bus.o_BEAT_DONE), 32'(exp_done));
    endtask

    task automatic run_beat(input string name, input logic [W-1:0] asu, input logic [W-1:0] exp_a,
                            input logic [W-1:0] exp_par, input int req_at);
        sb_q.push_back(exp_par);
        $display("beat %s: asu=%02h expect a_data=%02h acc_par=%02h", name, asu, exp_a, exp_par);
        for (int i = 0; i < W; i++)
            one_strobe(asu[i], i == req_at, i, exp_a[i], i == W - 1);
        @(posedge clk); #1;
        check("done_clear", 32'(bus.o_BEAT_DONE), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] stall_word;
        checks = 0;
        errors = 0;
        stall_word = 8'h96;
        rst = 1'b1;
        bus.i_RUN = 1'b1;
        bus.i_BIT_EN = 1'b0;
        bus.i_WRITE = 1'b0;
        bus.i_CLEAR = 1'b0;
        bus.i_ASU_DATA = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_data", 32'(bus.o_A_DATA), 32'd0);
        check("rst_xtb", 32'(bus.o_XTB), 32'd1);
        check("rst_idx", 32'(bus.o_BIT_IDX), 32'd0);
        check("rst_done", 32'(bus.o_BEAT_DONE), 32'd0);
        check("rst_par", 32'(bus.o_ACC_PAR), 32'd0);
        check("rst_neg", 32'(bus.o_NEG), 32'd0);
        $display("reset: a_data=%0b xtb=%0b idx=%0d par=%02h", bus.o_A_DATA, bus.o_XTB, bus.o_BIT_IDX, bus.o_ACC_PAR);
        rst = 1'b0;
        @(posedge clk); #1;

        run_beat("recirc0", 8'hFF, 8'h00, 8'h00, -1);
        pulse_req(1'b1, 1'b0);
        run_beat("write4D", 8'h4D, 8'h00, 8'h4D, -1);
        run_beat("recirc4D", 8'hFF, 8'h4D, 8'h4D, -1);
        pulse_req(1'b1, 1'b0);
        run_beat("writeF0", 8'hF0, 8'h4D, 8'hF0, -1);
        pulse_req(1'b1, 1'b1);
        run_beat("clear", 8'hFF, 8'hF0, 8'h00, -1);
        run_beat("midreq", 8'hAA, 8'h00, 8'h00, 3);
        run_beat("write3C", 8'h3C, 8'h00, 8'h3C, -1);
        run_beat("same_cycle", stall_word, 8'h3C, stall_word, 0);

        // Stall at idx 5 with strobes still running.
        sb_q.push_back(stall_word);
        $display("beat stall: expect acc_par=%02h", stall_word);
        for (int i = 0; i < 5; i++)
            one_strobe(1'b0, 1'b0, i, stall_word[i], 1'b0);
        bus.i_RUN = 1'b0;
        bus.i_BIT_EN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("stall_idx", 32'(bus.o_BIT_IDX), 32'd5);
            check("stall_a_data", 32'(bus.o_A_DATA), 32'(stall_word[5]));
            check("stall_xtb", 32'(bus.o_XTB), 32'd0);
            check("stall_done", 32'(bus.o_BEAT_DONE), 32'd0);
        end
        bus.i_BIT_EN = 1'b0;
        bus.i_RUN = 1'b1;
        for (int i = 5; i < W; i++)
            one_strobe(1'b0, 1'b0, i, stall_word[i], i == W - 1);
        @(posedge clk); #1;

        // Reset four bits into a write beat of all ones.
        pulse_req(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            one_strobe(1'b1, 1'b0, i, stall_word[i], 1'b0);
        rst = 1'b1;
        bus.i_BIT_EN = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_BIT_EN = 1'b0;
        check("midrst_par", 32'(bus.o_ACC_PAR), 32'd0);
        check("midrst_idx", 32'(bus.o_BIT_IDX), 32'd0);
        check("midrst_done", 32'(bus.o_BEAT_DONE), 32'd0);
        $display("mid-beat reset: idx=%0d par=%02h", bus.o_BIT_IDX, bus.o_ACC_PAR);
        run_beat("after_rst", 8'hFF, 8'h00, 8'h00, -1);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
